// File: rtl/alu_pipe32_if.sv
// Handshake and data bundle for alu_pipe32: operand side (in_*, a, b, op)
// and result side (out_*, f, flags). The slave modport is the ALU's view.
interface alu_pipe32_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] f;
    logic             zero;
    logic             neg;
    logic             carry;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, f, zero, neg, carry
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, f, zero, neg, carry
    );
endinterface

// File: rtl/alu_pipe32.sv
// Two-stage pipelined ALU (AND/OR/XOR/ADD) with valid/ready on both sides.
// Define ALU_PIPE_FLAGS_EN to build the zero/neg/carry flag registers; otherwise they are tied to 0.

module and32 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_y
);
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        assign o_y[gi] = i_a[gi] & i_b[gi];
    end
endmodule

module alu_pipe32 #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    alu_pipe32_if.slave  bus
);
    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_ADD = 2'b11;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [1:0]       r_op;
    logic             r_s1_v;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_f;

    logic             w_s2_adv;
    logic             w_in_ready;
    logic             w_accept;
    logic [WIDTH-1:0] w_and;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_result;

    // S2 can take new data whenever it is empty or being drained this cycle.
    assign w_s2_adv   = !r_out_valid || bus.out_ready;
    assign w_in_ready = !rst && (!r_s1_v || w_s2_adv);
    assign w_accept   = bus.in_valid && w_in_ready;

    and32 #(.WIDTH(WIDTH)) u_and (
        .i_a (r_a),
        .i_b (r_b),
        .o_y (w_and)
    );

`ifdef ALU_PIPE_FLAGS_EN
    logic w_carry;
    assign {w_carry, w_sum} = {1'b0, r_a} + {1'b0, r_b};
`else
    assign w_sum = r_a + r_b;
`endif

    always_comb begin
        w_result = w_and;
        case (r_op)
            OP_AND:  w_result = w_and;
            OP_OR:   w_result = r_a | r_b;
            OP_XOR:  w_result = r_a ^ r_b;
            OP_ADD:  w_result = w_sum;
            default: w_result = w_and;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= OP_AND;
            r_s1_v      <= 1'b0;
            r_out_valid <= 1'b0;
            r_f         <= '0;
        end else begin
            if (w_accept) begin
                r_a    <= bus.a;
                r_b    <= bus.b;
                r_op   <= bus.op;
                r_s1_v <= 1'b1;
            end else if (w_s2_adv) begin
                r_s1_v <= 1'b0;
            end

            if (w_s2_adv) begin
                r_out_valid <= r_s1_v;
                if (r_s1_v) begin
                    r_f <= w_result;
                end
            end
        end
    end

`ifdef ALU_PIPE_FLAGS_EN
    logic r_zero;
    logic r_neg;
    logic r_carry;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_zero  <= 1'b0;
            r_neg   <= 1'b0;
            r_carry <= 1'b0;
        end else if (w_s2_adv && r_s1_v) begin
            r_zero  <= (w_result == '0);
            r_neg   <= w_result[WIDTH-1];
            r_carry <= (r_op == OP_ADD) ? w_carry : 1'b0;
        end
    end

    assign bus.zero  = r_zero;
    assign bus.neg   = r_neg;
    assign bus.carry = r_carry;
`else
    assign bus.zero  = 1'b0;
    assign bus.neg   = 1'b0;
    assign bus.carry = 1'b0;
`endif

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.f         = r_f;
endmodule

// File: doc/alu_pipe32.md
# alu_pipe32

Two-stage pipelined 32-bit ALU front end that accepts operand pairs and an opcode over a valid/ready handshake. It registers the operands, evaluates the selected operation using the existing 32-bit bitwise units (`and32` for AND, plus OR, XOR and ADD), and holds the result and flags in an output register until the downstream consumer takes them. It sits between the operand source (register file or testbench driver) and the result writeback/consumer, and isolates the combinational `and32`-class units behind registers on both sides.

## Interface
- `WIDTH`, 32, datapath width; all operand, result and flag logic scales with it.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  upstream presents `a`, `b`, `op`.
- `in_ready`  out  1  stage 1 can accept this cycle.
- `a`  in  WIDTH  operand A.
- `b`  in  WIDTH  operand B.
- `op`  in  2  00 AND, 01 OR, 10 XOR, 11 ADD.
- `out_valid`  out  1  `f` and flags are valid.
- `out_ready`  in  1  downstream accepts this cycle.
- `f`  out  WIDTH  result.
- `zero`  out  1  f == 0.
- `neg`  out  1  f[WIDTH-1].
- `carry`  out  1  carry-out of ADD; 0 for logic ops.

## Operation
- Stage 1 (S1): registers `a`, `b`, `op` and a valid bit `s1_v`.
- Stage 2 (S2): registers the computed result, flags and `out_valid`.
- Transfer-in occurs on an edge where `in_valid && in_ready`.
- Transfer-out occurs on an edge where `out_valid && out_ready`.
- `s2_adv = !out_valid || out_ready`. S1 moves into S2 on `s2_adv`; if `s1_v` = 0 at that point, `out_valid` clears on the edge.
- `in_ready = !rst && (!s1_v || s2_adv)`. This is combinational, with no combinational path from `in_valid` to `in_ready`.
- When S1 advances and no new input arrives, `s1_v` clears. Simultaneous accept and advance refills S1 on the same edge.
- AND uses an `and32` instance. OR, XOR and ADD are computed in S1→S2 logic.
- ADD is WIDTH+1 bits: the low WIDTH bits go to `f` and the MSB goes to `carry`. Overflow wraps modulo 2^WIDTH.
- Results are produced strictly in input order, with no drop and no duplication.
- While stalled (`out_valid && !out_ready`), `f` and the flags are held stable.
- Reset values: `s1_v`=0, `out_valid`=0, `f`=0, `zero`=0, `neg`=0, `carry`=0, S1 operand registers 0. `in_ready`=0 while `rst` is high and 1 in the first cycle after.
- Reset asserted mid-operation discards every in-flight transaction. No output appears for them after reset deasserts.

## Timing
- Latency: a transaction accepted at edge N has `out_valid`=1 after edge N+1, i.e. its result is visible in the cycle following the capture edge of S2.
- Throughput: 1 transaction per cycle with `out_ready` held high.
- Capacity: at most 2 transactions in flight, one each in S1 and S2. With `out_ready` low, the third offered transaction sees `in_ready`=0.
- `in_ready` reasserts in the same cycle `out_ready` rises, if S2 is full, S1 is full and S2 drains.

## Configuration
- `ALU_PIPE_FLAGS_EN`:
  - Defined: `zero`, `neg` and `carry` are computed and registered in S2 as above.
  - Undefined: the flag registers and logic are removed, and `zero`, `neg` and `carry` are constant 0. `f`, the handshake and latency are unchanged.

## Test plan
- Reset, then `a`=32'h80000001, `b`=32'h80000001, op=AND with `out_ready`=1. Required response: f=32'h80000001, neg=1, zero=0, carry=0, with `out_valid` one cycle after acceptance.
- Back-to-back AND 4'b1000&4'b1010, OR 32'h0000F000|32'h0000000F, XOR 32'hFFFFFFFF^32'hFFFFFFFF. Required response: f=32'h8, then 32'h0000F00F, then 32'h0 with zero=1, on consecutive cycles.
- ADD 32'hFFFFFFFF+32'h1. Required response: f=0, zero=1, carry=1. ADD 32'h7FFFFFFF+1 gives f=32'h80000000, neg=1, carry=0.
- `out_ready`=0, then offer three transactions. Required response: two are accepted and `in_ready` drops. Raise `out_ready`: all three emerge in order, and `f` is held stable during the stall.
- Assert `rst` for one cycle with both stages full. Required response: `out_valid`=0 and `f`=0 afterward, and no stale result ever appears.
- Build without `ALU_PIPE_FLAGS_EN`, run ADD 32'hFFFFFFFF+1. Required response: f=0, zero=neg=carry=0.
